// File: rtl/regfile_cmd_sequencer.sv
// regfile_cmd_sequencer
//   Initiator for a 16x16 register file. Takes one register-level command at
//   a time, reads both operands, computes a result, commits it through the
//   write port and hands the result plus flags back over a valid/ready port.
//   CLR walks every register and writes zero, one per cycle.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/dst/srca/srcb/imm     command fields, latched on acceptance
//   rf_write/rf_DA/rf_AA/rf_BA   registered register-file control
//   rf_D                         registered register-file write data
//   rf_A/rf_B                    register-file read data (combinational)
//   res_valid/res_ready          result handshake
//   res_data/res_zero/res_carry  result value and flags
module regfile_cmd_sequencer #(
  parameter int bit_width  = 16,
  parameter int addr_width = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [addr_width-1:0] cmd_dst,
  input  logic [addr_width-1:0] cmd_srca,
  input  logic [addr_width-1:0] cmd_srcb,
  input  logic [bit_width-1:0]  cmd_imm,
  output logic                  rf_write,
  output logic [addr_width-1:0] rf_DA,
  output logic [addr_width-1:0] rf_AA,
  output logic [addr_width-1:0] rf_BA,
  output logic [bit_width-1:0]  rf_D,
  input  logic [bit_width-1:0]  rf_A,
  input  logic [bit_width-1:0]  rf_B,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [bit_width-1:0]  res_data,
  output logic                  res_zero,
  output logic                  res_carry
);

  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_RD  = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  // CLR reports how many registers it cleared.
  localparam logic [bit_width-1:0]  SWEEP_COUNT = bit_width'(1 << addr_width);
  localparam logic [addr_width-1:0] CNT_LAST    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WB,
    S_RESP,
    S_SWEEP
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [addr_width-1:0] dst_q, dst_d;
  logic [bit_width-1:0]  imm_q, imm_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [addr_width-1:0] da_q, da_d;
  logic [addr_width-1:0] aa_q, aa_d;
  logic [addr_width-1:0] ba_q, ba_d;
  logic [bit_width-1:0]  d_q, d_d;
  // Result held between READ and WB so RD (which never loads rf_D) still
  // has its value available when the response is published.
  logic [bit_width-1:0]  pend_data_q, pend_data_d;
  logic                  pend_carry_q, pend_carry_d;
  logic                  res_valid_q, res_valid_d;
  logic [bit_width-1:0]  res_data_q, res_data_d;
  logic                  res_zero_q, res_zero_d;
  logic                  res_carry_q, res_carry_d;

  logic [bit_width:0]    alu_out;

  // The extra MSB is the carry for ADD and the borrow for SUB (the top bit of
  // a zero-extended subtraction is set exactly when a < b); it is zero for
  // every other op because the operands are zero-extended.
  function automatic logic [bit_width:0] alu(
    input logic [2:0]           op,
    input logic [bit_width-1:0] a,
    input logic [bit_width-1:0] b,
    input logic [bit_width-1:0] imm
  );
    logic [bit_width:0] r;
    r = '0;
    case (op)
      OP_LDI:         r = {1'b0, imm};
      OP_MOV, OP_RD:  r = {1'b0, a};
      OP_ADD:         r = {1'b0, a} + {1'b0, b};
      OP_SUB:         r = {1'b0, a} - {1'b0, b};
      OP_AND:         r = {1'b0, a & b};
      OP_XOR:         r = {1'b0, a ^ b};
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign alu_out = alu(op_q, rf_A, rf_B, imm_q);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    imm_d        = imm_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    da_d         = da_q;
    aa_d         = aa_q;
    ba_d         = ba_q;
    d_d          = d_q;
    pend_data_d  = pend_data_q;
    pend_carry_d = pend_carry_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_zero_d   = res_zero_q;
    res_carry_d  = res_carry_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          imm_d = cmd_imm;
          aa_d  = cmd_srca;
          ba_d  = cmd_srcb;
          if (cmd_op == OP_CLR) begin
            // First sweep write is presented straight away so register 0
            // commits on the first SWEEP edge.
            write_d = 1'b1;
            da_d    = '0;
            d_d     = '0;
            cnt_d   = '0;
            state_d = S_SWEEP;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        pend_data_d  = alu_out[bit_width-1:0];
        pend_carry_d = alu_out[bit_width];
        if (op_q != OP_RD) begin
          write_d = 1'b1;
          da_d    = dst_q;
          d_d     = alu_out[bit_width-1:0];
        end
        state_d = S_WB;
      end

      S_WB: begin
        write_d     = 1'b0;
        res_valid_d = 1'b1;
        res_data_d  = pend_data_q;
        res_zero_d  = (pend_data_q == '0);
        res_carry_d = pend_carry_q;
        state_d     = S_RESP;
      end

      S_RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_SWEEP: begin
        // cnt_q is the register whose clear commits at this edge.
        if (cnt_q == CNT_LAST) begin
          write_d     = 1'b0;
          cnt_d       = '0;
          res_valid_d = 1'b1;
          res_data_d  = SWEEP_COUNT;
          res_zero_d  = 1'b0;
          res_carry_d = 1'b0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          da_d  = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      da_q         <= '0;
      aa_q         <= '0;
      ba_q         <= '0;
      d_q          <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_zero_q   <= 1'b0;
      res_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      da_q         <= da_d;
      aa_q         <= aa_d;
      ba_q         <= ba_d;
      d_q          <= d_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_zero_q   <= res_zero_d;
      res_carry_q  <= res_carry_d;
    end
  end

  // Latched command fields and the pending result are only consumed after
  // being loaded, so they need no reset.
  always_ff @(posedge clock) begin
    op_q         <= op_d;
    dst_q        <= dst_d;
    imm_q        <= imm_d;
    pend_data_q  <= pend_data_d;
    pend_carry_q <= pend_carry_d;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rf_write  = write_q;
  assign rf_DA     = da_q;
  assign rf_AA     = aa_q;
  assign rf_BA     = ba_q;
  assign rf_D      = d_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_carry = res_carry_q;

endmodule
